// File: rtl/mux_param_rr.sv
// =============================================================================
// mux_param_rr : N-channel holding-register mux, fixed-selector or round-robin
// Optional round-robin arbitration built only when MUX_ROUNDROBIN_EN is defined.
// Revision 1.0
// =============================================================================
`default_nettype none

module mux_param_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk_4f,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] Entrada,
  input  logic [CHANNELS-1:0]       validEntrada,
  output logic [CHANNELS-1:0]       readyEntrada,
  input  logic                      modo,
  input  logic [SELW-1:0]           selector,
  output logic [WIDTH-1:0]          Salida,
  output logic                      validSalida,
  input  logic                      readySalida,
  output logic [SELW-1:0]           canalSalida,
  output logic [15:0]               conteo
);

  logic [CHANNELS-1:0] hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0]    hold_data_q [CHANNELS];
  logic [WIDTH-1:0]    hold_data_d [CHANNELS];
  logic [WIDTH-1:0]    salida_q, salida_d;
  logic                valid_q, valid_d;
  logic [SELW-1:0]     canal_q, canal_d;
  logic [15:0]         conteo_q, conteo_d;

  logic                out_free;
  logic                grant_valid;
  logic [SELW-1:0]     grant_idx;
  logic [CHANNELS-1:0] grant_oh;

`ifdef MUX_ROUNDROBIN_EN
  logic [SELW-1:0]     ptr_q, ptr_d;
`else
  logic                unused_modo;
  assign unused_modo = modo;
`endif

  assign out_free = ~valid_q | readySalida;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
`ifdef MUX_ROUNDROBIN_EN
    if (out_free && modo) begin
      // Search starts one past the last granted channel, wrapping to 0.
      for (int k = 1; k <= CHANNELS; k++) begin
        int idx;
        idx = (int'(ptr_q) + k) % CHANNELS;
        if (!grant_valid && hold_valid_q[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = idx[SELW-1:0];
        end
      end
    end else if (out_free) begin
      if ((int'(selector) < CHANNELS) && hold_valid_q[selector]) begin
        grant_valid = 1'b1;
        grant_idx   = selector;
      end
    end
`else
    if (out_free && (int'(selector) < CHANNELS) && hold_valid_q[selector]) begin
      grant_valid = 1'b1;
      grant_idx   = selector;
    end
`endif
  end

  assign grant_oh     = grant_valid ? (CHANNELS'(1) << grant_idx) : '0;
  assign readyEntrada = reset ? '0 : (~hold_valid_q | grant_oh);

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    salida_d     = salida_q;
    valid_d      = valid_q;
    canal_d      = canal_q;
    conteo_d     = conteo_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (validEntrada[i] && readyEntrada[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_data_d[i]  = Entrada[i*WIDTH +: WIDTH];
      end else if (grant_oh[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end
    if (grant_valid) begin
      salida_d = hold_data_q[grant_idx];
      canal_d  = grant_idx;
      valid_d  = 1'b1;
    end else if (out_free) begin
      valid_d  = 1'b0;
    end
    if (valid_q && readySalida) begin
      conteo_d = conteo_q + 16'd1;
    end
  end

`ifdef MUX_ROUNDROBIN_EN
  assign ptr_d = grant_valid ? grant_idx : ptr_q;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      ptr_q <= SELW'(CHANNELS - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      hold_valid_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        hold_data_q[i] <= '0;
      end
      salida_q <= '0;
      valid_q  <= 1'b0;
      canal_q  <= '0;
      conteo_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      salida_q     <= salida_d;
      valid_q      <= valid_d;
      canal_q      <= canal_d;
      conteo_q     <= conteo_d;
    end
  end

  assign Salida      = salida_q;
  assign validSalida = valid_q;
  assign canalSalida = canal_q;
  assign conteo      = conteo_q;

endmodule

`default_nettype wire
